// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port request sequencer in front of the byte-addressed data memory.
// Each accepted request is checked, driven to memory for one cycle, then answered with a one-cycle pulse.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 4096
`endif

module dmem_arbiter #(
   parameter int MEM_BYTES     = `MEM_SIZE,
   parameter bit CORE_PRIORITY = 1'b1,
   parameter int MAX_STARVE    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p0_req_valid,
   output logic             p0_req_ready,
   input  logic             p0_we,
   input  logic [1:0]       p0_size,
   input  logic             p0_unsigned,
   input  logic [`XLEN-1:0] p0_addr,
   input  logic [`XLEN-1:0] p0_wdata,
   output logic             p0_rsp_valid,
   output logic             p0_rsp_err,
   output logic [`XLEN-1:0] p0_rdata,
   input  logic             p1_req_valid,
   output logic             p1_req_ready,
   input  logic             p1_we,
   input  logic [1:0]       p1_size,
   input  logic             p1_unsigned,
   input  logic [`XLEN-1:0] p1_addr,
   input  logic [`XLEN-1:0] p1_wdata,
   output logic             p1_rsp_valid,
   output logic             p1_rsp_err,
   output logic [`XLEN-1:0] p1_rdata,
   output logic [`XLEN-1:0] mem_address,
   output logic [`XLEN-1:0] mem_WriteData,
   output logic [3:0]       mem_wr_en,
   output logic [1:0]       mem_load_type,
   output logic             mem_MemRead,
   input  logic [`XLEN-1:0] mem_ReadData,
   output logic [1:0]       dbg_state
);
   localparam int XLEN = `XLEN;
   localparam logic [XLEN:0] MEM_LIMIT  = (XLEN+1)'(MEM_BYTES);
   localparam logic [3:0]    STARVE_LIM = 4'(MAX_STARVE);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t          state;
   logic            own;
   logic            t_we, t_uns, t_err;
   logic [1:0]      t_size;
   logic            rr_ptr;
   logic [3:0]      starve;

   logic            grant0, grant1, accept;
   logic            a_we, a_uns, a_err;
   logic [1:0]      a_size;
   logic [XLEN-1:0] a_addr, a_wdata;
   logic [XLEN:0]   a_nbytes, a_end;
   logic [3:0]      a_lanes;
   logic [XLEN-1:0] ld_val;

   assign dbg_state = state;

   // Handshake: a request transfers on a rising edge where req_valid and req_ready are both
   // high. ready may depend on valid; a requester holds valid and payload stable until then.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset && (state != ACCESS)) begin
         if (p0_req_valid && p1_req_valid) begin
            if (CORE_PRIORITY) begin
               if (starve == STARVE_LIM) grant1 = 1'b1;
               else                      grant0 = 1'b1;
            end else if (rr_ptr) begin
               grant1 = 1'b1;
            end else begin
               grant0 = 1'b1;
            end
         end else begin
            grant0 = p0_req_valid;
            grant1 = p1_req_valid;
         end
      end
   end

   assign p0_req_ready = grant0;
   assign p1_req_ready = grant1;
   assign accept       = grant0 | grant1;

   assign a_we    = grant1 ? p1_we       : p0_we;
   assign a_uns   = grant1 ? p1_unsigned : p0_unsigned;
   assign a_size  = grant1 ? p1_size     : p0_size;
   assign a_addr  = grant1 ? p1_addr     : p0_addr;
   assign a_wdata = grant1 ? p1_wdata    : p0_wdata;

   always_comb begin
      a_nbytes = (XLEN+1)'(4);
      a_lanes  = 4'b0000;
      case (a_size)
         2'b00:   begin a_nbytes = (XLEN+1)'(1); a_lanes = 4'b0001; end
         2'b01:   begin a_nbytes = (XLEN+1)'(2); a_lanes = 4'b0011; end
         2'b10:   begin a_nbytes = (XLEN+1)'(4); a_lanes = 4'b1111; end
         default: begin a_nbytes = (XLEN+1)'(4); a_lanes = 4'b0000; end
      endcase
   end

   // One extra bit so an address near the top of the space cannot wrap past the limit.
   assign a_end = {1'b0, a_addr} + a_nbytes;
   assign a_err = (a_size == 2'b11)
                | ((a_size == 2'b01) && a_addr[0])
                | ((a_size == 2'b10) && (a_addr[1:0] != 2'b00))
                | (a_end > MEM_LIMIT);

   // Memory already sign-extends sub-word reads; only the unsigned variants need zeroing.
   always_comb begin
      ld_val = '0;
      if (!t_err && !t_we) begin
         case (t_size)
            2'b00:   ld_val = t_uns ? {{(XLEN-8){1'b0}}, mem_ReadData[7:0]} : mem_ReadData;
            2'b01:   ld_val = t_uns ? {{(XLEN-16){1'b0}}, mem_ReadData[15:0]} : mem_ReadData;
            default: ld_val = mem_ReadData;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         own           <= 1'b0;
         t_we          <= 1'b0;
         t_uns         <= 1'b0;
         t_err         <= 1'b0;
         t_size        <= 2'b00;
         rr_ptr        <= 1'b0;
         starve        <= 4'd0;
         mem_address   <= '0;
         mem_WriteData <= '0;
         mem_wr_en     <= 4'b0000;
         mem_load_type <= 2'b00;
         mem_MemRead   <= 1'b0;
         p0_rsp_valid  <= 1'b0;
         p0_rsp_err    <= 1'b0;
         p0_rdata      <= '0;
         p1_rsp_valid  <= 1'b0;
         p1_rsp_err    <= 1'b0;
         p1_rdata      <= '0;
      end else begin
         mem_address   <= '0;
         mem_WriteData <= '0;
         mem_wr_en     <= 4'b0000;
         mem_load_type <= 2'b00;
         mem_MemRead   <= 1'b0;
         p0_rsp_valid  <= 1'b0;
         p0_rsp_err    <= 1'b0;
         p1_rsp_valid  <= 1'b0;
         p1_rsp_err    <= 1'b0;

         if (CORE_PRIORITY) begin
            if (!p1_req_valid || grant1) starve <= 4'd0;
            else if (grant0)             starve <= starve + 4'd1;
         end
         if (grant0)      rr_ptr <= 1'b1;
         else if (grant1) rr_ptr <= 1'b0;

         case (state)
            ACCESS: begin
               state <= RESP;
               if (own) begin
                  p1_rsp_valid <= 1'b1;
                  p1_rsp_err   <= t_err;
                  p1_rdata     <= ld_val;
               end else begin
                  p0_rsp_valid <= 1'b1;
                  p0_rsp_err   <= t_err;
                  p0_rdata     <= ld_val;
               end
            end
            default: begin
               if (accept) begin
                  state         <= ACCESS;
                  own           <= grant1;
                  t_we          <= a_we;
                  t_uns         <= a_uns;
                  t_err         <= a_err;
                  t_size        <= a_size;
                  mem_address   <= a_addr;
                  mem_load_type <= a_size;
                  mem_WriteData <= a_we ? a_wdata : '0;
                  if (!a_err) begin
                     mem_wr_en   <= a_we ? a_lanes : 4'b0000;
                     mem_MemRead <= !a_we;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table on a little-endian memory model, plus reset and
// contention sequences on a fixed-priority and a round-robin instance sharing the same requests.
module tb_dmem_arbiter;
   localparam int MB = 256;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        p0_req_valid = 0, p0_we = 0, p0_unsigned = 0;
   logic [1:0]  p0_size = 0;
   logic [31:0] p0_addr = 0, p0_wdata = 0;
   logic        p1_req_valid = 0, p1_we = 0, p1_unsigned = 0;
   logic [1:0]  p1_size = 0;
   logic [31:0] p1_addr = 0, p1_wdata = 0;

   logic        p0_req_ready, p0_rsp_valid, p0_rsp_err;
   logic        p1_req_ready, p1_rsp_valid, p1_rsp_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] mem_address, mem_WriteData, mem_ReadData;
   logic [3:0]  mem_wr_en;
   logic [1:0]  mem_load_type, dbg_state;
   logic        mem_MemRead;

   logic        r_p0_req_ready, r_p0_rsp_valid, r_p0_rsp_err;
   logic        r_p1_req_ready, r_p1_rsp_valid, r_p1_rsp_err;
   logic [31:0] r_p0_rdata, r_p1_rdata;
   logic [31:0] r_mem_address, r_mem_WriteData;
   logic [31:0] r_mem_ReadData = 32'h0;
   logic [3:0]  r_mem_wr_en;
   logic [1:0]  r_mem_load_type, r_dbg_state;
   logic        r_mem_MemRead;

   dmem_arbiter #(.MEM_BYTES(MB), .CORE_PRIORITY(1'b1), .MAX_STARVE(8)) dut (
      .clk(clk), .reset(reset),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
      .p0_size(p0_size), .p0_unsigned(p0_unsigned), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_err(p0_rsp_err), .p0_rdata(p0_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
      .p1_size(p1_size), .p1_unsigned(p1_unsigned), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_err(p1_rsp_err), .p1_rdata(p1_rdata),
      .mem_address(mem_address), .mem_WriteData(mem_WriteData), .mem_wr_en(mem_wr_en),
      .mem_load_type(mem_load_type), .mem_MemRead(mem_MemRead), .mem_ReadData(mem_ReadData),
      .dbg_state(dbg_state)
   );

   dmem_arbiter #(.MEM_BYTES(MB), .CORE_PRIORITY(1'b0), .MAX_STARVE(8)) dut_rr (
      .clk(clk), .reset(reset),
      .p0_req_valid(p0_req_valid), .p0_req_ready(r_p0_req_ready), .p0_we(p0_we),
      .p0_size(p0_size), .p0_unsigned(p0_unsigned), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rsp_valid(r_p0_rsp_valid), .p0_rsp_err(r_p0_rsp_err), .p0_rdata(r_p0_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(r_p1_req_ready), .p1_we(p1_we),
      .p1_size(p1_size), .p1_unsigned(p1_unsigned), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rsp_valid(r_p1_rsp_valid), .p1_rsp_err(r_p1_rsp_err), .p1_rdata(r_p1_rdata),
      .mem_address(r_mem_address), .mem_WriteData(r_mem_WriteData), .mem_wr_en(r_mem_wr_en),
      .mem_load_type(r_mem_load_type), .mem_MemRead(r_mem_MemRead), .mem_ReadData(r_mem_ReadData),
      .dbg_state(r_dbg_state)
   );

   // Little-endian byte memory: sign-extending combinational read, lane writes at posedge.
   logic [7:0] tb_mem [MB];
   logic [7:0] i0, i1, i2, i3, b0, b1, b2, b3;
   assign i0 = mem_address[7:0];
   assign i1 = i0 + 8'd1;
   assign i2 = i0 + 8'd2;
   assign i3 = i0 + 8'd3;
   assign b0 = tb_mem[i0];
   assign b1 = tb_mem[i1];
   assign b2 = tb_mem[i2];
   assign b3 = tb_mem[i3];
   always_comb begin
      case (mem_load_type)
         2'b00:   mem_ReadData = {{24{b0[7]}}, b0};
         2'b01:   mem_ReadData = {{16{b1[7]}}, b1, b0};
         default: mem_ReadData = {b3, b2, b1, b0};
      endcase
   end
   always @(posedge clk) begin
      if (mem_wr_en[0]) tb_mem[i0] <= mem_WriteData[7:0];
      if (mem_wr_en[1]) tb_mem[i1] <= mem_WriteData[15:8];
      if (mem_wr_en[2]) tb_mem[i2] <= mem_WriteData[23:16];
      if (mem_wr_en[3]) tb_mem[i3] <= mem_WriteData[31:24];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        port;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  wr_en;
   } vec_t;

   function automatic vec_t mk(input logic p, input logic we, input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd, input logic e,
                               input logic [31:0] rd, input logic [3:0] wen);
      vec_t v;
      v.port = p; v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
      v.err = e; v.rdata = rd; v.wr_en = wen;
      return v;
   endfunction

   task automatic drive_req(input logic p, input logic v, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd);
      if (p) begin
         p1_req_valid = v; p1_we = we; p1_size = sz; p1_unsigned = uns; p1_addr = a; p1_wdata = wd;
      end else begin
         p0_req_valid = v; p0_we = we; p0_size = sz; p0_unsigned = uns; p0_addr = a; p0_wdata = wd;
      end
   endtask

   function automatic logic ready_of(input logic p);
      return p ? p1_req_ready : p0_req_ready;
   endfunction
   function automatic logic rspv_of(input logic p);
      return p ? p1_rsp_valid : p0_rsp_valid;
   endfunction
   function automatic logic rspe_of(input logic p);
      return p ? p1_rsp_err : p0_rsp_err;
   endfunction
   function automatic logic [31:0] rdata_of(input logic p);
      return p ? p1_rdata : p0_rdata;
   endfunction

   // Drive one request, then check the ACCESS cycle, the RESP pulse and its single-cycle width.
   task automatic do_txn(input vec_t v, input string tag);
      int n;
      logic [3:0] wr_seen;
      @(negedge clk);
      drive_req(v.port, 1'b1, v.we, v.size, v.uns, v.addr, v.wdata);
      #1;
      n = 0;
      while (!ready_of(v.port) && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({tag, "_ready"}, 32'(ready_of(v.port)), 32'd1);
      if (!ready_of(v.port)) begin
         drive_req(v.port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
         return;
      end
      @(negedge clk);
      drive_req(v.port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      wr_seen = mem_wr_en;
      chk({tag, "_wr_en"}, 32'(wr_seen), 32'(v.wr_en));
      chk({tag, "_memread"}, 32'(mem_MemRead), 32'(!v.we && !v.err));
      chk({tag, "_no_early_rsp"}, 32'(rspv_of(v.port)), 32'd0);
      @(negedge clk);
      chk({tag, "_rsp_valid"}, 32'(rspv_of(v.port)), 32'd1);
      chk({tag, "_rsp_err"}, 32'(rspe_of(v.port)), 32'(v.err));
      chk({tag, "_rdata"}, rdata_of(v.port), v.rdata);
      chk({tag, "_wr_en_resp"}, 32'(mem_wr_en), 32'd0);
      @(negedge clk);
      chk({tag, "_rsp_pulse"}, 32'(rspv_of(v.port)), 32'd0);
   endtask

   vec_t vecs [19];
   int   gp_port[$], gp_cyc[$], gr_port[$], gr_cyc[$];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < MB; i++) tb_mem[i] = 8'h00;

      // Reset state, with both requests asserted so ready gating under reset is visible.
      p0_req_valid = 1'b1;
      p1_req_valid = 1'b1;
      #2;
      chk("rst_p0_ready", 32'(p0_req_ready), 32'd0);
      chk("rst_p1_ready", 32'(p1_req_ready), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_mem_addr", mem_address, 32'd0);
      chk("rst_memread", 32'(mem_MemRead), 32'd0);
      chk("rst_rsp", 32'({p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err}), 32'd0);
      chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      vecs[0]  = mk(0, 1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 0, 32'h0,        4'hF);
      vecs[1]  = mk(0, 0, 2'b10, 0, 32'h10,   32'h0,        0, 32'hDEADBEEF, 4'h0);
      vecs[2]  = mk(0, 0, 2'b00, 0, 32'h13,   32'h0,        0, 32'hFFFFFFDE, 4'h0);
      vecs[3]  = mk(0, 0, 2'b00, 1, 32'h13,   32'h0,        0, 32'h000000DE, 4'h0);
      vecs[4]  = mk(0, 0, 2'b01, 1, 32'h12,   32'h0,        0, 32'h0000DEAD, 4'h0);
      vecs[5]  = mk(0, 0, 2'b01, 0, 32'h12,   32'h0,        0, 32'hFFFFDEAD, 4'h0);
      vecs[6]  = mk(0, 1, 2'b10, 0, 32'h11,   32'hCAFEF00D, 1, 32'h0,        4'h0);
      vecs[7]  = mk(0, 0, 2'b10, 0, 32'h10,   32'h0,        0, 32'hDEADBEEF, 4'h0);
      vecs[8]  = mk(0, 0, 2'b01, 0, 32'h03,   32'h0,        1, 32'h0,        4'h0);
      vecs[9]  = mk(0, 0, 2'b11, 0, 32'h10,   32'h0,        1, 32'h0,        4'h0);
      vecs[10] = mk(0, 0, 2'b10, 0, MB - 2,   32'h0,        1, 32'h0,        4'h0);
      vecs[11] = mk(0, 0, 2'b10, 0, MB - 4,   32'h0,        0, 32'h0,        4'h0);
      vecs[12] = mk(0, 0, 2'b01, 0, MB - 2,   32'h0,        0, 32'h0,        4'h0);
      vecs[13] = mk(0, 0, 2'b00, 0, MB,       32'h0,        1, 32'h0,        4'h0);
      vecs[14] = mk(1, 1, 2'b00, 0, 32'h41,   32'h000000A5, 0, 32'h0,        4'h1);
      vecs[15] = mk(1, 0, 2'b00, 0, 32'h41,   32'h0,        0, 32'hFFFFFFA5, 4'h0);
      vecs[16] = mk(1, 1, 2'b01, 0, 32'h42,   32'h00008001, 0, 32'h0,        4'h3);
      vecs[17] = mk(0, 0, 2'b10, 0, 32'h40,   32'h0,        0, 32'h8001A500, 4'h0);
      vecs[18] = mk(1, 0, 2'b01, 1, 32'h42,   32'h0,        0, 32'h00008001, 4'h0);
      for (int i = 0; i < 19; i++) do_txn(vecs[i], $sformatf("v%0d", i));

      // Reset in the middle of a store's ACCESS cycle: the write is dropped and no response follows.
      @(negedge clk);
      drive_req(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
      #1;
      chk("ar_ready", 32'(p0_req_ready), 32'd1);
      @(negedge clk);
      drive_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      chk("ar_wr_en_access", 32'(mem_wr_en), 32'hF);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_wr_en_dropped", 32'(mem_wr_en), 32'd0);
      chk("ar_state", 32'(dbg_state), 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("ar_no_rsp", 32'(p0_rsp_valid), 32'd0);
      end
      reset = 1'b1;
      do_txn(mk(0, 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h0, 4'h0), "ar_lw");

      // Contention: both ports request continuously; record grants on both instances.
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      drive_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      drive_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
      for (int c = 0; c < 44; c++) begin
         #1;
         chk("prio_both_ready", 32'(p0_req_ready & p1_req_ready), 32'd0);
         chk("rr_both_ready", 32'(r_p0_req_ready & r_p1_req_ready), 32'd0);
         if (p0_req_ready) begin gp_port.push_back(0); gp_cyc.push_back(c); end
         if (p1_req_ready) begin gp_port.push_back(1); gp_cyc.push_back(c); end
         if (r_p0_req_ready) begin gr_port.push_back(0); gr_cyc.push_back(c); end
         if (r_p1_req_ready) begin gr_port.push_back(1); gr_cyc.push_back(c); end
         @(negedge clk);
      end
      drive_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      drive_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

      chk("prio_grant_count", 32'(gp_port.size()), 32'd22);
      for (int k = 0; k < gp_port.size(); k++) begin
         chk($sformatf("prio_grant%0d", k), 32'(gp_port[k]), (k % 9 == 8) ? 32'd1 : 32'd0);
         if (k > 0) chk($sformatf("prio_gap%0d", k), 32'(gp_cyc[k] - gp_cyc[k-1]), 32'd2);
      end
      chk("rr_grant_count", 32'(gr_port.size()), 32'd22);
      for (int k = 0; k < gr_port.size(); k++) begin
         chk($sformatf("rr_grant%0d", k), 32'(gr_port[k]), 32'(k % 2));
         if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(gr_cyc[k] - gr_cyc[k-1]), 32'd2);
      end

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
